xvc_jtag_shift_ctrl: RTL
========================

Name: xvc_jtag_shift_ctrl

Overview:
- Sequences one Xilinx Virtual Cable "shift" command onto the board JTAG pins: up to 32 TCK cycles with per-bit TMS/TDI and captured TDO.
- Sits between the PCIe block-design register space (host writes vectors/length, pulses start, polls busy/done) and the physical TCK/TMS/TDI/TDO pins.
- Host software splits longer XVC shifts into 32-bit chunks.
- Runs on the 100 MHz system clock; TCK rate set at runtime by a half-period divider.

Parameters:
- HALF_W, 8, width of the half_period input (TCK phase length counter).
- TMS_RESET, 1, value driven on tms while in reset.

Ports:
- clk100  input  1  system clock, 100 MHz; sole clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle command strobe, sampled only in IDLE.
- len  input  6  bits to shift; 0 = no-op; 33..63 clamp to 32.
- half_period  input  HALF_W  TCK phase length minus one, in clk100 cycles.
- tms_vec  input  32  TMS bits, bit 0 shifted first.
- tdi_vec  input  32  TDI bits, bit 0 shifted first.
- tdo_vec  output  32  captured TDO, bit i = bit captured on TCK cycle i.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at command completion.
- tck  output  1  JTAG clock.
- tms  output  1  JTAG mode select.
- tdi  output  1  JTAG data to target.
- tdo  input  1  JTAG data from target (pre-synchronised externally).

Behaviour:
- One clock (clk100); synchronous active-high reset.
- Reset values: tck=0, tms=TMS_RESET, tdi=0, busy=0, done=0, tdo_vec=0, state IDLE. Reset mid-command aborts immediately; no further TCK edges.
- States: IDLE, LOW, HIGH, FIN. All outputs registered.
- IDLE, start=1, eff_len = min(len,32):
  - eff_len=0: go to FIN. No TCK edge. tdo_vec cleared.
  - Otherwise: latch vectors, eff_len and half_period h. Clear tdo_vec. Bit index i=0.
  - Next cycle: busy=1, tck=0, tms=tms_vec[0], tdi=tdi_vec[0]. Enter LOW.
- LOW: lasts h+1 cycles with tck=0, then enter HIGH with tck=1.
- HIGH: lasts h+1 cycles with tck=1.
  - On the last HIGH cycle, sample tdo into tdo_vec[i].
  - If i==eff_len-1, go to FIN.
  - Else i++, drive tck=0 with tms/tdi = bit i (same cycle as the falling edge), and re-enter LOW.
- FIN: one cycle. done=1, busy=0, tck=0. tms/tdi hold their last values. Return to IDLE.
- TMS/TDI change only coincident with TCK falling edges. Target sees them stable for h+1 cycles before each rising edge.
- Timing:
  - busy is high from the cycle after start through the last HIGH cycle.
  - Total busy duration is eff_len*2*(h+1) cycles; done follows in the next cycle.
  - TCK frequency = 100 MHz / (2*(h+1)).
- start is ignored while busy=1 or in FIN; no queueing.
- half_period and vector inputs may change during a command without effect (latched at start).
- tdo_vec holds its value from done until the next accepted start. Bits at index >= eff_len read 0.
- tms/tdi hold their last values in IDLE, so the TAP state is unchanged between commands.

Test Plan:
- len=1, h=0, tms_vec=1, tdi_vec=0, tdo tied 1 -> exactly one TCK pulse (1 cycle low, 1 high); tms=1 during pulse; done 3 cycles after start; tdo_vec=0x00000001.
- len=32, h=3, tdi_vec=0xA5C3_0F96, tdo looped to tdi through a target-model TAP capturing on rising TCK -> 32 TCK pulses, busy high 256 cycles; tdo_vec=0xA5C3_0F96; TCK period 8 cycles.
- len=0 with start -> no TCK edge; done 1 cycle after start; busy never asserts; tdo_vec=0.
- len=40, h=0 -> clamped to 32 pulses, busy 64 cycles; start pulsed again mid-command -> ignored, still exactly 32 pulses and one done.
- reset asserted at pulse 10 of a len=20 command -> next cycle tck=0, tms=1, busy=0, tdo_vec=0; no done pulse; fresh start then runs normally.
- TMS walk: tms_vec=0x1F, len=5, then tms_vec=0x0, len=1 -> target-model TAP reaches Test-Logic-Reset then Run-Test/Idle; tms never toggles while tck=1.

Source files
------------

// File: rtl/xvc_jtag_shift_ctrl.sv
// XVC shift sequencer: up to 32 TCK cycles with per-bit TMS/TDI, TDO capture.
// TCK phase length is (half_period + 1) clk100 cycles, latched at start.
module xvc_jtag_shift_ctrl #(
    parameter int HALF_W    = 8,
    parameter bit TMS_RESET = 1'b1
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        len,
    input  logic [HALF_W-1:0] half_period,
    input  logic [31:0]       tms_vec,
    input  logic [31:0]       tdi_vec,
    output logic [31:0]       tdo_vec,
    output logic              busy,
    output logic              done,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_cnt;
    logic [5:0]        r_len;
    logic [4:0]        r_idx;
    logic [31:0]       r_tms_sh;
    logic [31:0]       r_tdi_sh;
    logic [31:0]       r_tdo;
    logic              r_busy;
    logic              r_done;
    logic              r_tck;
    logic              r_tms;
    logic              r_tdi;

    logic [5:0]        w_eff_len;
    logic              w_phase_end;
    logic              w_last;

    assign w_eff_len   = (len > 6'd32) ? 6'd32 : len;
    assign w_phase_end = (r_cnt == r_half);
    assign w_last      = ({1'b0, r_idx} == (r_len - 6'd1));

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_eff_len == 6'd0) ? S_FIN : S_LOW;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_next = w_last ? S_FIN : S_LOW;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_half   <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_tms_sh <= '0;
            r_tdi_sh <= '0;
            r_tdo    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tck    <= 1'b0;
            r_tms    <= TMS_RESET;
            r_tdi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_tdo <= '0;
                        if (w_eff_len == 6'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_half   <= half_period;
                            r_len    <= w_eff_len;
                            r_tms_sh <= tms_vec;
                            r_tdi_sh <= tdi_vec;
                            r_cnt    <= '0;
                            r_idx    <= '0;
                            r_busy   <= 1'b1;
                            r_tck    <= 1'b0;
                            r_tms    <= tms_vec[0];
                            r_tdi    <= tdi_vec[0];
                        end
                    end
                end
                S_LOW: begin
                    if (w_phase_end) begin
                        r_tck <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_tdo[r_idx] <= tdo;
                        r_cnt        <= '0;
                        r_tck        <= 1'b0;
                        if (w_last) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            // next bit goes out on the same edge as TCK falls
                            r_idx    <= r_idx + 5'd1;
                            r_tms    <= r_tms_sh[1];
                            r_tdi    <= r_tdi_sh[1];
                            r_tms_sh <= r_tms_sh >> 1;
                            r_tdi_sh <= r_tdi_sh >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    r_tck <= 1'b0;
                end
                default: begin
                    r_tck <= 1'b0;
                end
            endcase
        end
    end

    assign tdo_vec = r_tdo;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tck     = r_tck;
    assign tms     = r_tms;
    assign tdi     = r_tdi;

endmodule
